// File: rtl/fpadd_param.sv
// fpadd_param: multi-cycle parameterised floating-point adder/subtractor.
// Operands flow through ALIGN, ADD, NORM and ROUND, one cycle each, then OUT.
module fpadd_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sub,
  input  logic [EXP_W+MAN_W:0]   reg_A,
  input  logic [EXP_W+MAN_W:0]   reg_B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   invalid,
  output logic                   overflow
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SH = MAN_W + 4;
  localparam int DW = $clog2(SH + 1);
  localparam int XW = EXP_W + 8;
  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] EONES = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q;
  logic          sl_q, ss_q;
  logic [EXP_W-1:0] el_q;
  logic [SH-1:0] gl_q, gs_q;
  logic          sp_q, spi_q;
  logic [W-1:0]  spr_q;
  logic [SH:0]   sum_q;
  logic [SH-1:0] ns_q;
  logic signed [XW-1:0] ne_q;
  logic          nz_q;
  logic [W-1:0]  res_q;
  logic          rinv_q, rovf_q;
  logic          ov_q;

  // align-stage combinational signals
  logic          a_big;
  logic [W-1:0]  lg, sm;
  logic [SH-1:0] lsig, ssig, al_s;
  logic [EXP_W-1:0] d;
  logic [DW-1:0] dc;
  logic [2*SH-1:0] ext;
  logic          na, nb, ia, ib, sp_hit, sp_inv;
  logic [W-1:0]  sp_res, qnan;

  assign a_big = a_q[W-2:0] >= b_q[W-2:0];
  assign lg    = a_big ? a_q : b_q;
  assign sm    = a_big ? b_q : a_q;
  assign lsig  = {|lg[W-2:MAN_W], lg[MAN_W-1:0], 3'b000};
  assign ssig  = {|sm[W-2:MAN_W], sm[MAN_W-1:0], 3'b000};
  assign d     = lg[W-2:MAN_W] - sm[W-2:MAN_W];
  assign dc    = (int'(d) > SH) ? DW'(SH) : DW'(d);
  assign ext   = {ssig, {SH{1'b0}}} >> dc;
  assign al_s  = {ext[2*SH-1:SH+1], ext[SH] | (|ext[SH-1:0])};

  assign na = (&a_q[W-2:MAN_W]) & (|a_q[MAN_W-1:0]);
  assign nb = (&b_q[W-2:MAN_W]) & (|b_q[MAN_W-1:0]);
  assign ia = (&a_q[W-2:MAN_W]) & ~(|a_q[MAN_W-1:0]);
  assign ib = (&b_q[W-2:MAN_W]) & ~(|b_q[MAN_W-1:0]);
  assign sp_hit = na | nb | ia | ib;
  assign sp_inv = na | nb | (ia & ib & (a_q[W-1] ^ b_q[W-1]));
  assign qnan = {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};
  assign sp_res = sp_inv ? qnan :
                  ia ? {a_q[W-1], EONES, {MAN_W{1'b0}}} :
                       {b_q[W-1], EONES, {MAN_W{1'b0}}};

  // normalise-stage combinational signals
  logic [DW-1:0] lz;
  logic [SH-1:0] shl, n_sig;
  logic signed [XW-1:0] elx, lzx, n_exp;

  assign elx = signed'({{(XW-EXP_W){1'b0}}, el_q});
  assign lzx = signed'({{(XW-DW){1'b0}}, lz});
  assign shl = sum_q[SH-1:0] << lz;

  // leading-zero count of the uncarried sum; highest set bit wins
  always_comb begin
    lz = '0;
    for (int i = 0; i < SH; i++)
      if (sum_q[i]) lz = DW'(SH - 1 - i);
  end

  // carry takes a sticky right shift, otherwise shift left by lz
  always_comb begin
    n_sig = shl;
    n_exp = elx - lzx;
    if (sum_q[SH]) begin
      n_sig = {sum_q[SH:2], sum_q[1] | sum_q[0]};
      n_exp = elx + ONE;
    end
  end

  // round-stage combinational signals
  logic          up;
  logic [MAN_W+1:0] rm;
  logic [MAN_W-1:0] rman;
  logic signed [XW-1:0] re;
  logic [W-1:0]  r_res;
  logic          r_ovf;

  assign up   = ns_q[2] & (ns_q[1] | ns_q[0] | ns_q[3]);
  assign rm   = {1'b0, ns_q[SH-1:3]} + {{(MAN_W+1){1'b0}}, up};
  assign rman = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
  assign re   = rm[MAN_W+1] ? ne_q + ONE : ne_q;

  // final result selection: zero, flush, overflow or normal
  always_comb begin
    r_res = {sl_q, re[EXP_W-1:0], rman};
    r_ovf = 1'b0;
    if (nz_q) begin
      r_res = {sl_q & ss_q, {(W-1){1'b0}}};
    end else if (re < ONE) begin
      r_res = {sl_q, {(W-1){1'b0}}};
    end else if (re >= EMAX) begin
      r_res = {sl_q, EONES, {MAN_W{1'b0}}};
      r_ovf = 1'b1;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_OUT;
      S_OUT:   if (ov_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = ov_q;

  // state register and output handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ov_q     <= 1'b0;
      out      <= '0;
      invalid  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_OUT && !ov_q) begin
        out      <= res_q;
        invalid  <= rinv_q;
        overflow <= rovf_q;
        ov_q     <= 1'b1;
      end else if (ov_q && out_ready) begin
        ov_q <= 1'b0;
      end
    end
  end

  // datapath stage registers, loaded by the stage that owns them
  always_ff @(posedge clk) begin
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        a_q <= reg_A;
        b_q <= {reg_B[W-1] ^ sub, reg_B[W-2:0]};
      end
      S_ALIGN: begin
        sl_q  <= lg[W-1];
        ss_q  <= sm[W-1];
        el_q  <= lg[W-2:MAN_W];
        gl_q  <= lsig;
        gs_q  <= al_s;
        sp_q  <= sp_hit;
        spi_q <= sp_inv;
        spr_q <= sp_res;
      end
      S_ADD: sum_q <= (sl_q ^ ss_q) ? {1'b0, gl_q} - {1'b0, gs_q}
                                    : {1'b0, gl_q} + {1'b0, gs_q};
      S_NORM: begin
        ns_q <= n_sig;
        ne_q <= n_exp;
        nz_q <= ~(|sum_q);
      end
      S_ROUND: begin
        res_q  <= sp_q ? spr_q : r_res;
        rinv_q <= sp_q & spi_q;
        rovf_q <= ~sp_q & r_ovf;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpadd_param.sv
// tb_fpadd_param: random and directed checks of fpadd_param against
// an exact-integer rounding model, for float32 and a 5/10 format.
module tb_fpadd_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] in_valid_v = '0;
  logic [1:0] sub_v = '0;
  logic [1:0] out_ready_v = '0;
  logic [1:0] in_ready_v, out_valid_v, inv_v, ovf_v;
  logic [63:0] a_v [2];
  logic [63:0] b_v [2];
  logic [31:0] out0;
  logic [15:0] out1;
  logic [63:0] out_v [2];

  int checks = 0;
  int failures = 0;

  assign out_v[0] = {32'b0, out0};
  assign out_v[1] = {48'b0, out1};

  always #5 clk = ~clk;

  fpadd_param u0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .sub(sub_v[0]),
    .reg_A(a_v[0][31:0]), .reg_B(b_v[0][31:0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out(out0), .invalid(inv_v[0]), .overflow(ovf_v[0])
  );

  fpadd_param #(.EXP_W(5), .MAN_W(10)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .sub(sub_v[1]),
    .reg_A(a_v[1][15:0]), .reg_B(b_v[1][15:0]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out(out1), .invalid(inv_v[1]), .overflow(ovf_v[1])
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact value arithmetic on wide integers, then round-to-nearest-even.
  function automatic void model(input int E, input int M,
                                input logic [63:0] a, input logic [63:0] b,
                                input bit s, output logic [63:0] r,
                                output bit inv, output bit ovf);
    int ones, ea, eb, el, es, d, dd, p, e, sh;
    bit sa, sb, sl, ss, na, nb, ia, ib;
    logic [63:0] mask, ma, mb, inf_s, qnan;
    logic [191:0] gl, gs, x, q, rem, half;
    ones = (1 << E) - 1;
    mask = (64'd1 << M) - 1;
    sa = a[E+M];
    sb = b[E+M] ^ s;
    ea = int'((a >> M) & 64'(ones));
    eb = int'((b >> M) & 64'(ones));
    ma = a & mask;
    mb = b & mask;
    na = ea == ones && ma != 0;
    nb = eb == ones && mb != 0;
    ia = ea == ones && ma == 0;
    ib = eb == ones && mb == 0;
    inv = 0;
    ovf = 0;
    qnan = (64'(ones) << M) | (64'd1 << (M - 1));
    if (na || nb || (ia && ib && sa != sb)) begin
      r = qnan; inv = 1; return;
    end
    if (ia || ib) begin
      inf_s = 64'(ia ? sa : sb);
      r = (inf_s << (E + M)) | (64'(ones) << M);
      return;
    end
    if (ea == 0 && eb == 0) begin
      r = 64'(sa && sb) << (E + M); return;
    end
    if (ea == 0) begin
      r = (64'(sb) << (E + M)) | (b & ((64'd1 << (E + M)) - 1)); return;
    end
    if (eb == 0) begin
      r = a; return;
    end
    if (ea > eb || (ea == eb && ma >= mb)) begin
      el = ea; es = eb; sl = sa; ss = sb;
      gl = 192'(ma) | (192'd1 << M); gs = 192'(mb) | (192'd1 << M);
    end else begin
      el = eb; es = ea; sl = sb; ss = sa;
      gl = 192'(mb) | (192'd1 << M); gs = 192'(ma) | (192'd1 << M);
    end
    d = el - es;
    dd = d > 120 ? 120 : d;
    if (d > 120) gs = 192'd1;
    x = (sl == ss) ? (gl << dd) + gs : (gl << dd) - gs;
    if (x == 0) begin
      r = 0; return;
    end
    p = 0;
    for (int i = 0; i < 192; i++) if (x[i]) p = i;
    e = (el - dd) + (p - M);
    if (p > M) begin
      sh = p - M;
      q = x >> sh;
      rem = x & ((192'd1 << sh) - 1);
      half = 192'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (192'd1 << (M + 1))) begin
        q = q >> 1; e = e + 1;
      end
    end else begin
      q = x << (M - p);
    end
    if (e <= 0) r = 64'(sl) << (E + M);
    else if (e >= ones) begin
      r = (64'(sl) << (E + M)) | (64'(ones) << M); ovf = 1;
    end else
      r = (64'(sl) << (E + M)) | (64'(e) << M) | (64'(q) & mask);
  endfunction

  task automatic do_op(input int u, input logic [63:0] a,
                       input logic [63:0] b, input bit s,
                       input int hold, output logic [63:0] got);
    logic [63:0] er, o_snap;
    bit ei, eo;
    int lat;
    int E, M;
    E = (u == 0) ? 8 : 5;
    M = (u == 0) ? 23 : 10;
    model(E, M, a, b, s, er, ei, eo);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready_v[u]), 64'd1);
    a_v[u] = a; b_v[u] = b; sub_v[u] = s; in_valid_v[u] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[u] = 1'b0;
    lat = 0;
    while (!out_valid_v[u] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd5);
    check("out", out_v[u], er);
    check("invalid", 64'(inv_v[u]), 64'(ei));
    check("overflow", 64'(ovf_v[u]), 64'(eo));
    o_snap = out_v[u];
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid_v[u]), 64'd1);
      check("hold_out", out_v[u], o_snap);
      check("hold_in_ready", 64'(in_ready_v[u]), 64'd0);
    end
    @(negedge clk);
    out_ready_v[u] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[u] = 1'b0;
    check("valid_drop", 64'(out_valid_v[u]), 64'd0);
    check("retain", out_v[u], er);
    got = out_v[u];
  endtask

  initial begin
    logic [63:0] got, a, b, wm;
    logic [63:0] sp [6];
    int E, M, bad;
    a_v[0] = 0; b_v[0] = 0; a_v[1] = 0; b_v[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready_v[0]), 64'd1);
    check("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
    check("rst_out", out_v[0], 64'd0);
    check("rst_invalid", 64'(inv_v[0]), 64'd0);
    check("rst_overflow", 64'(ovf_v[0]), 64'd0);

    do_op(0, 64'h3f800000, 64'h40000000, 0, 0, got);
    check("one_plus_two", got, 64'h40400000);
    do_op(0, 64'h40400000, 64'h3f800000, 1, 0, got);
    check("three_minus_one", got, 64'h40000000);
    do_op(0, 64'h3f800000, 64'h3f800000, 1, 0, got);
    check("cancel_zero", got, 64'h00000000);
    do_op(0, 64'h3f800000, 64'h33800000, 0, 0, got);
    check("tie_even_down", got, 64'h3f800000);
    do_op(0, 64'h3f800001, 64'h33800000, 0, 0, got);
    check("tie_even_up", got, 64'h3f800002);
    do_op(0, 64'h7f800000, 64'hff800000, 0, 0, got);
    check("inf_minus_inf", got, 64'h7fc00000);
    do_op(0, 64'h7f7fffff, 64'h7f7fffff, 0, 10, got);
    check("overflow_inf", got, 64'h7f800000);
    do_op(0, 64'h80000000, 64'h00000000, 1, 0, got);
    check("neg_zero", got, 64'h80000000);
    do_op(1, 64'h3c00, 64'h4000, 0, 0, got);
    check("half_1p2", got, 64'h4200);

    // reset while the operation sits in ADD
    @(negedge clk);
    a_v[0] = 64'h3f800000; b_v[0] = 64'h40000000; sub_v[0] = 0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready", 64'(in_ready_v[0]), 64'd1);
    check("midrst_out", out_v[0], 64'd0);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid_v[0]) bad++;
    end
    check("midrst_no_valid", 64'(bad), 64'd0);

    // in_valid during reset is ignored
    @(negedge clk);
    reset = 1'b1; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid_v[0] = 1'b0;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid_v[0] || !in_ready_v[0]) bad++;
    end
    check("rst_ignores_valid", 64'(bad), 64'd0);
    do_op(0, 64'h40a00000, 64'h3fc00000, 0, 0, got);
    check("after_rst", got, 64'h40d00000);

    for (int u = 0; u < 2; u++) begin
      E = (u == 0) ? 8 : 5;
      M = (u == 0) ? 23 : 10;
      wm = (64'd1 << (1 + E + M)) - 1;
      sp[0] = 0;
      sp[1] = 64'd1 << (E + M);
      sp[2] = 64'((1 << E) - 1) << M;
      sp[3] = sp[2] | sp[1];
      sp[4] = sp[2] | 64'd1;
      sp[5] = (64'd1 << (E + M)) - 1 - (64'd1 << M);
      for (int i = 0; i < ((u == 0) ? 160 : 60); i++) begin
        a = {$urandom, $urandom} & wm;
        b = {$urandom, $urandom} & wm;
        case ($urandom_range(0, 4))
          1: b = (a ^ 64'($urandom_range(0, 15))
                    ^ (64'($urandom_range(0, 1)) << (E + M)));
          2: b = a + (64'($urandom_range(0, 5)) << M);
          3: b = sp[$urandom_range(0, 5)];
          4: a = sp[$urandom_range(0, 5)];
          default: ;
        endcase
        do_op(u, a & wm, b & wm, 1'($urandom_range(0, 1)), 0, got);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpadd_param.md
FPADD_PARAM -- requirements
Module: fpadd_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-mantissa field width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands and op valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port sub  input  1  0: out=A+B; 1: out=A-B (B sign inverted on accept).
REQ-008 SHALL have port reg_A  input  W  operand A, IEEE-754-style {sign, exp, man}.
REQ-009 SHALL have port reg_B  input  W  operand B, same format.
REQ-010 SHALL have port out_valid  output  1  out and flags hold a new result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out  output  W  registered result.
REQ-013 SHALL have port invalid  output  1  result is NaN from inf-inf or NaN input.
REQ-014 SHALL have port overflow  output  1  finite operands rounded to infinity.

Function
REQ-015 SHALL implement FSM IDLE -> ALIGN -> ADD -> NORM -> ROUND -> OUT; one cycle each in ALIGN..ROUND.
REQ-016 in_ready SHALL be 1 only in IDLE; an operation is accepted on an edge where in_valid && in_ready, capturing reg_A, reg_B, sub.
REQ-017 out_valid SHALL rise exactly 5 cycles after the accepting edge and remain 1 in OUT until an edge with out_ready=1, then return to IDLE.
REQ-018 out and flags SHALL be stable while out_valid=1 and SHALL retain the last result after the handshake.
REQ-019 ALIGN: swap so larger magnitude is first; shift smaller significand right by exponent difference, keeping guard, round and sticky bits; difference >= MAN_W+3 yields significand 0 with sticky = OR of shifted-out bits.
REQ-020 ADD: signed magnitude add/subtract of (MAN_W+1)-bit significands with hidden bit, plus one carry bit.
REQ-021 NORM: single-cycle leading-zero count and left shift (or 1-bit right shift on carry), exponent adjusted accordingly.
REQ-022 ROUND: round-to-nearest-even using guard/round/sticky; mantissa carry-out increments exponent.
REQ-023 Subnormal inputs (exp=0) SHALL be treated as zero; results with exponent <= 0 SHALL flush to signed zero, no flag.
REQ-024 Exact-zero result SHALL be +0, except (-0)+(-0) (after sub inversion) gives -0.
REQ-025 Any NaN input, or inf plus opposite-sign inf, SHALL give canonical NaN {0, all-ones exp, MSB man=1, rest 0} with invalid=1.
REQ-026 inf plus finite or same-sign inf SHALL give that inf, flags 0.
REQ-027 Exponent reaching all-ones after rounding SHALL give signed inf with overflow=1.
REQ-028 invalid and overflow SHALL be updated with every result and be 0 for normal results.
REQ-029 Behaviour SHALL be correct for any EXP_W in 4..11 and MAN_W in 3..52.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE, in_ready=1, out_valid=0, out=0, invalid=0, overflow=0, from any state.
REQ-031 An operation in flight during reset SHALL be discarded; no out_valid for it afterward.
REQ-032 in_valid SHALL be ignored on any edge where reset=1.

Verification
REQ-033 Default params, sub=0, A=3f800000, B=40000000 -> out=40400000 exactly 5 cycles after accept, flags 0.
REQ-034 sub=1, A=40400000, B=3f800000 -> out=40000000; A=3f800000, B=3f800000 -> out=00000000.
REQ-035 A=3f800000, B=33800000 -> 3f800000 (tie to even); A=3f800001, B=33800000 -> 3f800002.
REQ-036 A=7f800000, B=ff800000 -> 7fc00000, invalid=1; A=7f7fffff, B=7f7fffff -> 7f800000, overflow=1.
REQ-037 out_ready held 0 for 10 cycles -> out_valid, out stable, in_ready=0; reset asserted in ADD -> out_valid never rises for that op, next op correct.
REQ-038 EXP_W=5, MAN_W=10: A=3c00, B=4000 -> out=4200.
